// File: rtl/spi_ram_ctrl.sv
// Command decoder and word memory behind an SPI slave: address/data commands
// with independent auto-incrementing write and read pointers.
module spi_ram_ctrl #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_SIZE+1:0] rx_data,
  input  logic                 rx_valid,
  output logic [ADDR_SIZE-1:0] tx_data,
  output logic                 tx_valid,
  output logic                 cmd_err
);

  localparam int                   IDX_W   = $clog2(MEM_DEPTH);
  localparam logic [ADDR_SIZE:0]   DEPTH_C = (ADDR_SIZE+1)'(MEM_DEPTH);
  localparam logic [ADDR_SIZE-1:0] LAST_C  = ADDR_SIZE'(MEM_DEPTH - 1);
  localparam logic [ADDR_SIZE-1:0] ONE_C   = {{(ADDR_SIZE-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    OP_WR_ADDR = 2'b00,
    OP_WR_DATA = 2'b01,
    OP_RD_ADDR = 2'b10,
    OP_RD_DATA = 2'b11
  } op_e;

  logic [ADDR_SIZE-1:0] mem_q [MEM_DEPTH];

  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
  logic                 wr_armed_q, wr_armed_d;
  logic                 rd_armed_q, rd_armed_d;
  logic [ADDR_SIZE-1:0] tx_data_q, tx_data_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 cmd_err_q, cmd_err_d;
  logic                 mem_we;

  op_e                  op;
  logic [ADDR_SIZE-1:0] payload;
  logic                 in_range;

  assign op       = op_e'(rx_data[ADDR_SIZE+1:ADDR_SIZE]);
  assign payload  = rx_data[ADDR_SIZE-1:0];
  assign in_range = {1'b0, payload} < DEPTH_C;

  // Pointers wrap at MEM_DEPTH, which need not be a power of two.
  function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
    return (a == LAST_C) ? '0 : a + ONE_C;
  endfunction

  always_comb begin
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    wr_armed_d = wr_armed_q;
    rd_armed_d = rd_armed_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = 1'b0;
    cmd_err_d  = 1'b0;
    mem_we     = 1'b0;
    if (rx_valid) begin
      case (op)
        OP_WR_ADDR: begin
          if (in_range) begin
            wr_addr_d  = payload;
            wr_armed_d = 1'b1;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        OP_WR_DATA: begin
          if (wr_armed_q) begin
            mem_we    = 1'b1;
            wr_addr_d = next_addr(wr_addr_q);
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        OP_RD_ADDR: begin
          if (in_range) begin
            rd_addr_d  = payload;
            rd_armed_d = 1'b1;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        OP_RD_DATA: begin
          if (rd_armed_q) begin
            tx_data_d  = mem_q[rd_addr_q[IDX_W-1:0]];
            tx_valid_d = 1'b1;
            rd_addr_d  = next_addr(rd_addr_q);
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        default: cmd_err_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      wr_armed_q <= 1'b0;
      rd_armed_q <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      wr_armed_q <= wr_armed_d;
      rd_armed_q <= rd_armed_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      cmd_err_q  <= cmd_err_d;
    end
  end

  // Storage is never cleared; reset only blocks a write in its own cycle.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      mem_q[wr_addr_q[IDX_W-1:0]] <= payload;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Bench for spi_ram_ctrl: directed scenarios plus random commands against a
// behavioural memory model; a second 128-word instance covers range rejection.
module tb_spi_ram_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic       rx_valid_s;
  logic [7:0] tx_data,  tx_data_s;
  logic       tx_valid, tx_valid_s;
  logic       cmd_err,  cmd_err_s;

  spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .cmd_err(cmd_err)
  );

  spi_ram_ctrl #(.MEM_DEPTH(128), .ADDR_SIZE(8)) dut_s (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid_s),
    .tx_data(tx_data_s), .tx_valid(tx_valid_s), .cmd_err(cmd_err_s)
  );

  always #5 clk = ~clk;

  int nerr    = 0;
  int nchecks = 0;

  // Reference model of the 256-word instance
  logic [7:0] m_mem [256];
  int         m_wa, m_ra;
  bit         m_wo, m_ro;
  logic [7:0] m_td;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_wa = 0; m_ra = 0; m_wo = 0; m_ro = 0; m_td = 8'h00;
  endtask

  task automatic send(input string tag, input logic [1:0] op, input logic [7:0] pl);
    bit exp_tv = 0;
    bit exp_ce = 0;
    case (op)
      2'd0: begin m_wa = int'(pl); m_wo = 1; end
      2'd1: if (m_wo) begin m_mem[m_wa] = pl; m_wa = (m_wa + 1) % 256; end
            else exp_ce = 1;
      2'd2: begin m_ra = int'(pl); m_ro = 1; end
      default: if (m_ro) begin m_td = m_mem[m_ra]; exp_tv = 1; m_ra = (m_ra + 1) % 256; end
               else exp_ce = 1;
    endcase
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = {op, pl};
    @(posedge clk);
    #1;
    chk({tag, ".tx_valid"}, 32'(tx_valid), 32'(exp_tv));
    chk({tag, ".cmd_err"},  32'(cmd_err),  32'(exp_ce));
    chk({tag, ".tx_data"},  32'(tx_data),  32'(m_td));
  endtask

  task automatic idle(input string tag);
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 10'($urandom);
    @(posedge clk);
    #1;
    chk({tag, ".tx_valid"}, 32'(tx_valid), 32'd0);
    chk({tag, ".cmd_err"},  32'(cmd_err),  32'd0);
    chk({tag, ".tx_data"},  32'(tx_data),  32'(m_td));
  endtask

  // Reset asserted in the same cycle as a command: command discarded.
  task automatic reset_with(input string tag, input logic [1:0] op, input logic [7:0] pl);
    @(negedge clk);
    rst_n    = 1'b0;
    rx_valid = 1'b1;
    rx_data  = {op, pl};
    @(posedge clk);
    #1;
    model_reset();
    chk({tag, ".tx_valid"}, 32'(tx_valid), 32'd0);
    chk({tag, ".cmd_err"},  32'(cmd_err),  32'd0);
    chk({tag, ".tx_data"},  32'(tx_data),  32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    rx_valid = 1'b0;
  endtask

  task automatic send_s(input string tag, input logic [1:0] op, input logic [7:0] pl,
                        input bit exp_tv, input bit exp_ce, input logic [7:0] exp_td);
    @(negedge clk);
    rx_valid_s = 1'b1;
    rx_data    = {op, pl};
    @(posedge clk);
    #1;
    chk({tag, ".tx_valid"}, 32'(tx_valid_s), 32'(exp_tv));
    chk({tag, ".cmd_err"},  32'(cmd_err_s),  32'(exp_ce));
    chk({tag, ".tx_data"},  32'(tx_data_s),  32'(exp_td));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [7:0] v;
    rst_n = 1'b0; rx_valid = 1'b0; rx_valid_s = 1'b0; rx_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.tx_data",    32'(tx_data),    32'd0);
    chk("rst.tx_valid",   32'(tx_valid),   32'd0);
    chk("rst.cmd_err",    32'(cmd_err),    32'd0);
    chk("rst_s.tx_data",  32'(tx_data_s),  32'd0);
    chk("rst_s.tx_valid", 32'(tx_valid_s), 32'd0);
    chk("rst_s.cmd_err",  32'(cmd_err_s),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Preload every word with a value whose top bit is set
    send("fill_addr", 2'd0, 8'h00);
    for (int i = 0; i < 256; i++) begin
      v = (i == 0) ? 8'hC3 : (8'h80 | 8'($urandom_range(0, 127)));
      send("fill", 2'd1, v);
    end

    // Reset keeps memory, clears pointers and arming
    @(negedge clk); rst_n = 1'b0; rx_valid = 1'b0;
    @(posedge clk); #1;
    model_reset();
    chk("rst2.tx_valid", 32'(tx_valid), 32'd0);
    chk("rst2.cmd_err",  32'(cmd_err),  32'd0);
    @(negedge clk); rst_n = 1'b1;

    send("unarmed_rd", 2'd3, 8'h00);
    send("unarmed_wr", 2'd1, 8'h55);
    idle("unarmed_idle");
    send("unarmed_ra", 2'd2, 8'h00);
    send("unarmed_chk", 2'd3, 8'h00);

    send("wr_rd.wa", 2'd0, 8'h10);
    send("wr_rd.wd", 2'd1, 8'hA5);
    send("wr_rd.ra", 2'd2, 8'h10);
    send("wr_rd.rd", 2'd3, 8'h00);
    chk("wr_rd.value", 32'(tx_data), 32'hA5);
    idle("wr_rd.hold");

    send("wrap.wa",  2'd0, 8'hFF);
    send("wrap.wd1", 2'd1, 8'h11);
    send("wrap.wd2", 2'd1, 8'h22);
    send("wrap.ra",  2'd2, 8'hFF);
    send("wrap.rd1", 2'd3, 8'h00);
    chk("wrap.first", 32'(tx_data), 32'h11);
    send("wrap.rd2", 2'd3, 8'h00);
    chk("wrap.second", 32'(tx_data), 32'h22);

    send("indep.ra", 2'd2, 8'h40);
    send("indep.wa", 2'd0, 8'h40);
    send("indep.wd", 2'd1, 8'h5A);
    send("indep.rd", 2'd3, 8'h00);
    chk("indep.value", 32'(tx_data), 32'h5A);

    send("b2b.ra",  2'd2, 8'h20);
    send("b2b.rd0", 2'd3, 8'h00);
    send("b2b.rd1", 2'd3, 8'h00);
    send("b2b.rd2", 2'd3, 8'h00);
    idle("b2b.idle");

    send("rstmid.wa", 2'd0, 8'h05);
    reset_with("rstmid.cyc", 2'd1, 8'h77);
    send("rstmid.wd", 2'd1, 8'h99);
    send("rstmid.ra", 2'd2, 8'h05);
    send("rstmid.rd", 2'd3, 8'h00);
    send("rstpend.ra", 2'd2, 8'h30);
    reset_with("rstpend.cyc", 2'd3, 8'h00);
    idle("rstpend.idle");

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) idle("rand.idle");
      else send("rand", 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
    end
    idle("rand.end");

    // 128-word instance: range rejection and wrap at 127
    send_s("s.ra_oor", 2'd2, 8'h80, 1'b0, 1'b1, 8'h00);
    send_s("s.rd_un",  2'd3, 8'h00, 1'b0, 1'b1, 8'h00);
    send_s("s.wa_oor", 2'd0, 8'h80, 1'b0, 1'b1, 8'h00);
    send_s("s.wd_un",  2'd1, 8'h33, 1'b0, 1'b1, 8'h00);
    send_s("s.wa",     2'd0, 8'h7F, 1'b0, 1'b0, 8'h00);
    send_s("s.wd1",    2'd1, 8'h33, 1'b0, 1'b0, 8'h00);
    send_s("s.wd2",    2'd1, 8'h44, 1'b0, 1'b0, 8'h00);
    send_s("s.ra",     2'd2, 8'h7F, 1'b0, 1'b0, 8'h00);
    send_s("s.ra_oor2", 2'd2, 8'hC0, 1'b0, 1'b1, 8'h00);
    send_s("s.rd1",    2'd3, 8'h00, 1'b1, 1'b0, 8'h33);
    send_s("s.rd2",    2'd3, 8'h00, 1'b1, 1'b0, 8'h44);
    @(negedge clk);
    rx_valid_s = 1'b0;
    @(posedge clk); #1;
    chk("s.idle.tx_valid", 32'(tx_valid_s), 32'd0);
    chk("s.idle.tx_data",  32'(tx_data_s),  32'h44);

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule

// File: doc/spi_ram_ctrl.md
SPI_RAM_CTRL -- requirements
Module: spi_ram_ctrl

Parameters
REQ-001 The block SHALL have parameter MEM_DEPTH, default 256, meaning the number of 8-bit memory words.
REQ-002 The block SHALL have parameter ADDR_SIZE, default 8, meaning the address and data width; the command word is ADDR_SIZE+2 bits wide.

Interface
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port rx_data, input, ADDR_SIZE+2 bits: command word from the SPI slave; [9:8] is the opcode, [7:0] is the payload.
REQ-006 The block SHALL have port rx_valid, input, 1 bit: rx_data is valid this cycle; single-cycle qualifier.
REQ-007 The block SHALL have port tx_data, output, ADDR_SIZE bits: read data returned to the SPI slave.
REQ-008 The block SHALL have port tx_valid, output, 1 bit: one-cycle pulse marking tx_data as new.
REQ-009 The block SHALL have port cmd_err, output, 1 bit: one-cycle pulse flagging a rejected command.

Function
REQ-010 The block SHALL act on rx_data only in cycles where rx_valid=1; when rx_valid=0, no internal state and no output changes except pulse deassertion.
REQ-011 Opcode 00 (WR_ADDR) SHALL load wr_addr with the payload and set flag wr_armed=1.
REQ-012 Opcode 01 (WR_DATA) with wr_armed=1 SHALL write the payload to mem[wr_addr] at that clock edge and set wr_addr to wr_addr+1, wrapping from MEM_DEPTH-1 to 0.
REQ-013 Opcode 10 (RD_ADDR) SHALL load rd_addr with the payload and set flag rd_armed=1; tx_valid and tx_data SHALL NOT change.
REQ-014 Opcode 11 (RD_DATA) with rd_armed=1 SHALL register tx_data <= mem[rd_addr], pulse tx_valid for exactly one cycle in the cycle after the rx_valid cycle, and set rd_addr to rd_addr+1 with the same wrap rule.
REQ-015 tx_data SHALL hold its last value until the next successful RD_DATA.
REQ-016 WR_DATA with wr_armed=0, or RD_DATA with rd_armed=0, SHALL pulse cmd_err for one cycle in the cycle after rx_valid, with no memory write and no tx_valid.
REQ-017 A WR_ADDR or RD_ADDR payload >= MEM_DEPTH SHALL be rejected: cmd_err pulses, and the address register and armed flag stay unchanged.
REQ-018 The write and read pointers SHALL be independent; a write to the address held by rd_addr, followed by RD_DATA, SHALL return the newly written value.
REQ-019 Back-to-back rx_valid in consecutive cycles SHALL each be processed; consecutive RD_DATA commands SHALL produce consecutive tx_valid pulses.
REQ-020 Memory contents SHALL NOT be cleared by reset; they are undefined until written.

Reset
REQ-021 When rst_n=0 at a clock edge, the block SHALL set tx_data=0, tx_valid=0, cmd_err=0, wr_addr=0, rd_addr=0, wr_armed=0 and rd_armed=0.
REQ-022 Reset SHALL take priority over rx_valid in the same cycle; the command in that cycle is discarded and no memory write occurs.
REQ-023 Reset SHALL cancel a pending tx_valid or cmd_err pulse scheduled for the following cycle.

Verification
REQ-024 Bench scenario, write then read: WR_ADDR 0x10, WR_DATA 0xA5, RD_ADDR 0x10, RD_DATA -> tx_data=0xA5 and a tx_valid pulse one cycle after the RD_DATA rx_valid.
REQ-025 Bench scenario, auto-increment with wrap: WR_ADDR 0xFF, WR_DATA 0x11, WR_DATA 0x22; RD_ADDR 0xFF, RD_DATA, RD_DATA -> tx_data reads 0x11 then 0x22, the second coming from address 0x00.
REQ-026 Bench scenario, unarmed access after reset: RD_DATA -> cmd_err pulses once and tx_valid stays 0; WR_DATA 0x55 -> cmd_err pulses and memory is unmodified.
REQ-027 Bench scenario, out-of-range address with MEM_DEPTH=128: RD_ADDR 0x80 -> cmd_err pulses; the subsequent RD_DATA still flags cmd_err because rd_armed stays 0.
REQ-028 Bench scenario, reset mid-operation: assert rst_n=0 in the same cycle as a WR_DATA 0x77 at an armed address 0x05 -> no write occurs, all outputs are 0, and a subsequent WR_DATA flags cmd_err.
REQ-029 Bench scenario, back-to-back reads: RD_ADDR 0x20, then three consecutive RD_DATA cycles -> three consecutive tx_valid pulses carrying mem[0x20], mem[0x21] and mem[0x22].
